// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter bank.
package counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STEP_W = 4;

endpackage

// File: rtl/counter_lane.sv
// One counter channel: count register, +/- step adder, wrap/saturate and sticky overflow.
module counter_lane
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_inc_en,
  input  logic [STEP_W-1:0] i_step,
  input  dir_e              i_dir,
  input  ovf_mode_e         i_mode,
  input  logic              i_ovf_clr,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_ovf
);

  localparam int unsigned PadW = WIDTH + 1 - STEP_W;

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_hit;
  logic [WIDTH-1:0] w_inc_val;
  logic [WIDTH-1:0] w_count_d;
  logic             w_ovf_d;

  // Next count and overflow; bit WIDTH of w_sum is carry (up) or borrow (down).
  always_comb begin
    w_step_ext = {{PadW{1'b0}}, i_step};
    if (i_dir == DIR_UP) begin
      w_sum = {1'b0, r_count} + w_step_ext;
    end else begin
      w_sum = {1'b0, r_count} - w_step_ext;
    end
    w_hit = w_sum[WIDTH];
    if (w_hit && (i_mode == OVF_SAT)) begin
      w_inc_val = (i_dir == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else begin
      w_inc_val = w_sum[WIDTH-1:0];
    end

    if (i_load) begin
      w_count_d = i_load_data;
    end else if (i_inc_en) begin
      w_count_d = w_inc_val;
    end else begin
      w_count_d = r_count;
    end

    // A fresh overflow beats a concurrent clear.
    w_ovf_d = (!i_load && i_inc_en && w_hit) || (r_ovf && !i_ovf_clr);
  end

  // Count and sticky overflow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/counter_bank.sv
// Multi-channel counter bank: NUM_CH lanes, write-address decode and registered read port.
module counter_bank
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned CH_AW  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [NUM_CH-1:0]        inc_en,
  input  logic [NUM_CH*STEP_W-1:0] inc_step,
  input  logic [NUM_CH-1:0]        dir,
  input  logic [NUM_CH-1:0]        sat_mode,
  input  logic                     wr_en,
  input  logic [CH_AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [CH_AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic [NUM_CH-1:0]        ovf_clr,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH*WIDTH-1:0]  count_flat
);

  logic [WIDTH-1:0] w_count [NUM_CH];
  logic [NUM_CH-1:0] w_load;
  logic [WIDTH-1:0] w_rd_mux;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    // Out-of-range write addresses match no lane.
    assign w_load[g] = wr_en && (wr_addr == CH_AW'(g));

    counter_lane #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_lane (
      .i_clk       (clk),
      .i_rst_n     (areset_n),
      .i_load      (w_load[g]),
      .i_load_data (wr_data),
      .i_inc_en    (inc_en[g]),
      .i_step      (inc_step[g*STEP_W +: STEP_W]),
      .i_dir       (dir_e'(dir[g])),
      .i_mode      (ovf_mode_e'(sat_mode[g])),
      .i_ovf_clr   (ovf_clr[g]),
      .o_count     (w_count[g]),
      .o_ovf       (ovf[g])
    );

    assign count_flat[g*WIDTH +: WIDTH] = w_count[g];
  end

  // Read mux on pre-update counts; unmatched addresses read as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == CH_AW'(i)) begin
        w_rd_mux = w_count[i];
      end
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank (WIDTH=8, NUM_CH=5 so address 5 is out of range).
module tb_counter_bank;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_CH = 5;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CH_AW  = $clog2(NUM_CH);

  logic                     clk;
  logic                     areset_n;
  logic [NUM_CH-1:0]        inc_en;
  logic [NUM_CH*STEP_W-1:0] inc_step;
  logic [NUM_CH-1:0]        dir;
  logic [NUM_CH-1:0]        sat_mode;
  logic                     wr_en;
  logic [CH_AW-1:0]         wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_en;
  logic [CH_AW-1:0]         rd_addr;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic [NUM_CH-1:0]        ovf_clr;
  logic [NUM_CH-1:0]        ovf;
  logic [NUM_CH*WIDTH-1:0]  count_flat;

  int total;
  int bad;

  counter_bank #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .STEP_W (STEP_W)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .inc_en     (inc_en),
    .inc_step   (inc_step),
    .dir        (dir),
    .sat_mode   (sat_mode),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ovf_clr    (ovf_clr),
    .ovf        (ovf),
    .count_flat (count_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    return count_flat[ch*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inc_en   = '0;
    inc_step = '0;
    dir      = '0;
    sat_mode = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ovf_clr  = '0;
  endtask

  task automatic load(input int ch, input logic [WIDTH-1:0] val);
    wr_en   = 1'b1;
    wr_addr = CH_AW'(ch);
    wr_data = val;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    idle();
    #3;
    total++; if (count_flat !== '0) begin bad++; $display("FAIL por_count got=%h exp=0", count_flat); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL por_ovf got=%b exp=0", ovf); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL por_rd_valid got=%b exp=0", rd_valid); end
    @(negedge clk);
    areset_n = 1'b1;
    tick();
    load(0, 8'h34);
    load(1, 8'hFF);
    rd_en = 1'b1; rd_addr = 0;
    inc_en = 5'b00011;
    inc_step[0 +: 4] = 4'd1;
    inc_step[4 +: 4] = 4'd1;
    tick();
    idle();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h34) begin
      bad++; $display("FAIL pre_rst_read got=%b/%h exp=1/34", rd_valid, rd_data); end
    total++; if (cnt(0) !== 8'h35 || ovf !== 5'b00010) begin
      bad++; $display("FAIL pre_rst_count got=%h/%b exp=35/00010", cnt(0), ovf); end
    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    areset_n = 1'b0;
    #1;
    total++; if (count_flat !== '0 || ovf !== '0) begin
      bad++; $display("FAIL async_rst_state got=%h/%b exp=0/0", count_flat, ovf); end
    total++; if (rd_data !== '0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst_read got=%h/%b exp=0/0", rd_data, rd_valid); end
    #1;
    areset_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap_up();
    load(1, 8'hFE);
    inc_en = 5'b00010;
    inc_step[4 +: 4] = 4'd3;
    tick();
    idle();
    total++; if (count_flat !== 40'h00_00_00_01_00) begin
      bad++; $display("FAIL wrap_up_count got=%h exp=0000000100", count_flat); end
    total++; if (ovf !== 5'b00010) begin
      bad++; $display("FAIL wrap_up_ovf got=%b exp=00010", ovf); end
  endtask

  task automatic test_ovf_clear();
    ovf_clr = 5'b00010;
    tick();
    idle();
    total++; if (ovf !== 5'b00000 || cnt(1) !== 8'h01) begin
      bad++; $display("FAIL ovf_clr got=%b/%h exp=00000/01", ovf, cnt(1)); end
    load(1, 8'hFF);
    inc_en = 5'b00010;
    inc_step[4 +: 4] = 4'd2;
    tick();
    idle();
    total++; if (ovf !== 5'b00010 || cnt(1) !== 8'h01) begin
      bad++; $display("FAIL ovf_reset_up got=%b/%h exp=00010/01", ovf, cnt(1)); end
    load(1, 8'hFF);
    total++; if (ovf !== 5'b00010 || cnt(1) !== 8'hFF) begin
      bad++; $display("FAIL load_keeps_ovf got=%b/%h exp=00010/ff", ovf, cnt(1)); end
    ovf_clr = 5'b00010;
    inc_en  = 5'b00010;
    inc_step[4 +: 4] = 4'd1;
    tick();
    idle();
    total++; if (ovf !== 5'b00010 || cnt(1) !== 8'h00) begin
      bad++; $display("FAIL clr_race got=%b/%h exp=00010/00", ovf, cnt(1)); end
  endtask

  task automatic test_saturate();
    load(2, 8'h02);
    inc_en = 5'b00100;
    inc_step[8 +: 4] = 4'd5;
    dir[2] = 1'b1;
    sat_mode[2] = 1'b1;
    tick();
    total++; if (cnt(2) !== 8'h00 || ovf[2] !== 1'b1) begin
      bad++; $display("FAIL sat_down got=%h/%b exp=00/1", cnt(2), ovf[2]); end
    tick();
    tick();
    idle();
    total++; if (cnt(2) !== 8'h00 || ovf !== 5'b00110) begin
      bad++; $display("FAIL sat_down_hold got=%h/%b exp=00/00110", cnt(2), ovf); end
    // Landing exactly on the top limit is not a clamp.
    load(4, 8'hFC);
    inc_en = 5'b10000;
    inc_step[16 +: 4] = 4'd3;
    sat_mode[4] = 1'b1;
    tick();
    total++; if (cnt(4) !== 8'hFF || ovf[4] !== 1'b0) begin
      bad++; $display("FAIL sat_exact got=%h/%b exp=ff/0", cnt(4), ovf[4]); end
    tick();
    idle();
    total++; if (cnt(4) !== 8'hFF || ovf[4] !== 1'b1) begin
      bad++; $display("FAIL sat_up_clamp got=%h/%b exp=ff/1", cnt(4), ovf[4]); end
    load(3, 8'h07);
    inc_en = 5'b01000;
    tick();
    idle();
    total++; if (cnt(3) !== 8'h07 || ovf[3] !== 1'b0) begin
      bad++; $display("FAIL step_zero got=%h/%b exp=07/0", cnt(3), ovf[3]); end
    load(0, 8'h01);
    inc_en = 5'b00001;
    inc_step[0 +: 4] = 4'd2;
    dir[0] = 1'b1;
    tick();
    idle();
    total++; if (cnt(0) !== 8'hFF || ovf[0] !== 1'b1) begin
      bad++; $display("FAIL wrap_down got=%h/%b exp=ff/1", cnt(0), ovf[0]); end
  endtask

  task automatic test_write_vs_inc();
    load(0, 8'd10);
    wr_en = 1'b1; wr_addr = 0; wr_data = 8'h55;
    inc_en = 5'b00001;
    inc_step[0 +: 4] = 4'd1;
    tick();
    wr_en = 1'b0;
    total++; if (cnt(0) !== 8'h55) begin
      bad++; $display("FAIL write_wins got=%h exp=55", cnt(0)); end
    tick();
    idle();
    total++; if (cnt(0) !== 8'h56) begin
      bad++; $display("FAIL inc_after_write got=%h exp=56", cnt(0)); end
  endtask

  task automatic test_read_timing();
    load(3, 8'd7);
    inc_en = 5'b01000;
    inc_step[12 +: 4] = 4'd1;
    rd_en = 1'b1; rd_addr = 3;
    wr_en = 1'b1; wr_addr = 3; wr_data = 8'd100;
    tick();
    idle();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'd7 || cnt(3) !== 8'd100) begin
      bad++; $display("FAIL read_old got=%b/%h/%h exp=1/07/64", rd_valid, rd_data, cnt(3)); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'd7) begin
      bad++; $display("FAIL read_hold got=%b/%h exp=0/07", rd_valid, rd_data); end
    rd_en = 1'b1; rd_addr = 5;
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      bad++; $display("FAIL read_oob got=%b/%h exp=1/00", rd_valid, rd_data); end
    rd_addr = 3;
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h64) begin
      bad++; $display("FAIL b2b_read_ch3 got=%b/%h exp=1/64", rd_valid, rd_data); end
    rd_addr = 0;
    tick();
    idle();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h56) begin
      bad++; $display("FAIL b2b_read_ch0 got=%b/%h exp=1/56", rd_valid, rd_data); end
  endtask

  task automatic test_write_oob();
    load(5, 8'hAA);
    load(7, 8'hBB);
    total++; if (count_flat !== 40'hFF_64_00_00_56) begin
      bad++; $display("FAIL write_oob got=%h exp=ff64000056", count_flat); end
  endtask

  initial begin
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    test_reset();
    test_wrap_up();
    test_ovf_clear();
    test_saturate();
    test_write_vs_inc();
    test_read_timing();
    test_write_oob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
